patch_window_sequencer: RTL

Downstream consumer of the layer-0 7x7 patch extractor. Captures each ready 7x7 patch into a local buffer and immediately pulses next_spatial_block, so the extractor refills while this block works. It then emits every KxK stride-1 window of the captured patch (16 windows of 4x4 by default) as flattened byte vectors to the systolic-array input stage over a valid/ready handshake.

---
 rtl/layer0_pkg.sv | 42 ++++
 rtl/patch_window_sequencer_if.sv | 41 ++++
 rtl/patch_window_sequencer_window_select.sv | 24 ++
 rtl/patch_window_sequencer.sv | 136 +++++++++++++
 4 files changed

// File: rtl/layer0_pkg.sv
// Shared layer-0 definitions: patch geometry, pixel/patch types and the
// window sequencer state encoding. Also used by the patch extractor.
package layer0_pkg;

    localparam int PATCH_SIZE  = 7;
    localparam int KERNEL_SIZE = 4;
    localparam int STRIDE      = 1;
    localparam int PADDING     = 0;
    localparam int DATA_W      = 8;
    localparam int WORD_W      = 32;
    localparam int BLK_CNT_W   = 10;

    // Windows per patch edge and per patch
    localparam int NW    = (PATCH_SIZE + 2 * PADDING - KERNEL_SIZE) / STRIDE + 1;
    localparam int NWIN  = NW * NW;
    localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int IDX_W = $clog2(PATCH_SIZE);
    localparam int WIN_W = KERNEL_SIZE * KERNEL_SIZE * DATA_W;

    typedef logic [DATA_W-1:0] pixel_t;
    // patch[row][col]
    typedef pixel_t [PATCH_SIZE-1:0][PATCH_SIZE-1:0] patch_t;
    typedef logic [PATCH_SIZE-1:0][PATCH_SIZE-1:0][WORD_W-1:0] patch_word_t;

    typedef enum logic [1:0] {
        ST_WAIT_PATCH = 2'd0,
        ST_EMIT       = 2'd1,
        ST_DONE       = 2'd2
    } state_t;

    // Keep only the pixel bits of each extractor word
    function automatic patch_t patch_low_bits(input patch_word_t words);
        patch_t p;
        for (int i = 0; i < PATCH_SIZE; i++) begin
            for (int j = 0; j < PATCH_SIZE; j++) begin
                p[i][j] = words[i][j][DATA_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/patch_window_sequencer_if.sv
// Bus between the patch extractor / systolic input stage and the sequencer.
//
// Window handshake: a window transfers on every rising clk edge where
// win_valid && win_ready. Once win_valid is high, win_data/win_row/win_col/
// win_last hold steady until that transfer; win_valid never drops without one.
// The patch side is level based: patch_valid (block_ready) stays high until the
// sequencer answers with a one-cycle next_spatial_block pulse.
interface patch_window_sequencer_if;
    import layer0_pkg::*;

    logic                 start;
    logic                 patch_valid;
    patch_word_t          patch_data;
    logic                 extraction_complete;
    logic                 next_spatial_block;
    logic [WIN_W-1:0]     win_data;
    logic                 win_valid;
    logic                 win_ready;
    logic [CNT_W-1:0]     win_row;
    logic [CNT_W-1:0]     win_col;
    logic                 win_last;
    logic                 block_done;
    logic                 all_done;
    logic [BLK_CNT_W-1:0] blk_count;
    state_t               dbg_state;

    // Environment side: extractor, consumer and controller
    modport master (
        output start, patch_valid, patch_data, extraction_complete, win_ready,
        input  next_spatial_block, win_data, win_valid, win_row, win_col,
               win_last, block_done, all_done, blk_count, dbg_state
    );

    // Sequencer side
    modport slave (
        input  start, patch_valid, patch_data, extraction_complete, win_ready,
        output next_spatial_block, win_data, win_valid, win_row, win_col,
               win_last, block_done, all_done, blk_count, dbg_state
    );

endinterface

// File: rtl/patch_window_sequencer_window_select.sv
// Window select: flattens the KxK window at origin (row, col) of the patch
// buffer. Byte k = patch[row + k/K][col + k%K], byte 0 in the LSBs.
module patch_window_sequencer_window_select
    import layer0_pkg::*;
(
    input  patch_t           i_patch,
    input  logic [CNT_W-1:0] i_row,
    input  logic [CNT_W-1:0] i_col,
    output logic [WIN_W-1:0] o_data
);

    logic [IDX_W-1:0] w_row_base;
    logic [IDX_W-1:0] w_col_base;

    assign w_row_base = IDX_W'(i_row);
    assign w_col_base = IDX_W'(i_col);

    for (genvar k = 0; k < KERNEL_SIZE * KERNEL_SIZE; k++) begin : g_byte
        localparam logic [IDX_W-1:0] KR = IDX_W'(k / KERNEL_SIZE);
        localparam logic [IDX_W-1:0] KC = IDX_W'(k % KERNEL_SIZE);
        assign o_data[k*DATA_W +: DATA_W] = i_patch[w_row_base + KR][w_col_base + KC];
    end

endmodule

// File: rtl/patch_window_sequencer.sv
// Patch window sequencer: captures a 7x7 patch from the extractor, releases
// the extractor at once with next_spatial_block, then streams every KxK
// stride-1 window of the captured patch in row-major order.
module patch_window_sequencer
    import layer0_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    patch_window_sequencer_if.slave bus
);

    state_t               r_state;
    state_t               w_next_state;
    logic                 r_armed;
    patch_t               r_buf;
    logic [CNT_W-1:0]     r_row;
    logic [CNT_W-1:0]     r_col;
    logic                 r_nsb;
    logic                 r_block_done;
    logic [BLK_CNT_W-1:0] r_blk_count;

    logic                 w_capture;
    logic                 w_hs;
    logic                 w_at_last;
    logic                 w_rearm;
    logic [WIN_W-1:0]     w_sel_data;

    // armed blocks recapture of the stale patch while block_ready is still high
    assign w_capture = (r_state == ST_WAIT_PATCH) && bus.patch_valid && r_armed;
    assign w_hs      = (r_state == ST_EMIT) && bus.win_ready;
    assign w_at_last = (r_row == CNT_W'(NW - 1)) && (r_col == CNT_W'(NW - 1));
    assign w_rearm   = (r_state == ST_DONE) && bus.start;

    patch_window_sequencer_window_select u_window_select (
        .i_patch (r_buf),
        .i_row   (r_row),
        .i_col   (r_col),
        .o_data  (w_sel_data)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_WAIT_PATCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; capture wins over extraction_complete
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_WAIT_PATCH: begin
                if (w_capture) begin
                    w_next_state = ST_EMIT;
                end else if (bus.extraction_complete) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_EMIT: begin
                if (w_hs && w_at_last) begin
                    w_next_state = ST_WAIT_PATCH;
                end
            end
            ST_DONE: begin
                if (bus.start) begin
                    w_next_state = ST_WAIT_PATCH;
                end
            end
            default: w_next_state = ST_WAIT_PATCH;
        endcase
    end

    // Outputs decoded from state, counters and registered pulses
    always_comb begin
        bus.win_valid          = (r_state == ST_EMIT);
        bus.win_last           = (r_state == ST_EMIT) && w_at_last;
        bus.win_data           = (r_state == ST_EMIT) ? w_sel_data : '0;
        bus.win_row            = r_row;
        bus.win_col            = r_col;
        bus.all_done           = (r_state == ST_DONE);
        bus.next_spatial_block = r_nsb;
        bus.block_done         = r_block_done;
        bus.blk_count          = r_blk_count;
        bus.dbg_state          = r_state;
    end

    // Control registers: armed flag, window counters, pulses, block counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed      <= 1'b1;
            r_row        <= '0;
            r_col        <= '0;
            r_nsb        <= 1'b0;
            r_block_done <= 1'b0;
            r_blk_count  <= '0;
        end else begin
            r_nsb        <= w_capture;
            r_block_done <= w_hs && w_at_last;

            if (w_capture) begin
                r_armed <= 1'b0;
            end else if (!bus.patch_valid || w_rearm) begin
                r_armed <= 1'b1;
            end

            // Row-major walk; the last window wraps both counters back to 0
            if (w_capture) begin
                r_row <= '0;
                r_col <= '0;
            end else if (w_hs) begin
                if (r_col == CNT_W'(NW - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == CNT_W'(NW - 1)) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end

            if (w_rearm) begin
                r_blk_count <= '0;
            end else if (w_hs && w_at_last) begin
                r_blk_count <= r_blk_count + 1'b1;
            end
        end
    end

    // Patch buffer: written only on capture so extractor reloads cannot leak in
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_buf <= patch_low_bits(bus.patch_data);
        end
    end

endmodule
